// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx: DVP-style camera byte-stream generator driven by internal test patterns.
// Emits RGB565 (high byte first) with an active-high VSYNC pulse and HREF framing, standing
// in for an image sensor in front of the camera receive path.
//
// Ports:
//   clk          byte clock, one cmos_data byte per cycle
//   rst_n        asynchronous active-low reset
//   en           run request, acted on only at frame boundaries
//   pattern_sel  0 colour bars, 1 horizontal ramp, 2 line index, 3 solid (latched per frame)
//   color_i      solid colour for pattern 3 (latched per frame)
//   cmos_vsyn    frame sync, active high
//   cmos_href    line valid
//   cmos_data    pixel byte, 0 while href is low
//   frame_cnt    completed frames, wraps
//   frame_done   one-cycle pulse in the last front-porch cycle
//   busy         high whenever a frame is in progress
module cam_dvp_tx #(
  parameter int unsigned H_PIX     = 800,
  parameter int unsigned H_BLANK   = 144,
  parameter int unsigned V_LINES   = 480,
  parameter int unsigned VS_LINES  = 3,
  parameter int unsigned VBP_LINES = 17,
  parameter int unsigned VFP_LINES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] color_i,
  output logic        cmos_vsyn,
  output logic        cmos_href,
  output logic [7:0]  cmos_data,
  output logic [15:0] frame_cnt,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned LineLen  = 2 * H_PIX + H_BLANK;
  localparam int unsigned ActBytes = 2 * H_PIX;
  localparam int unsigned BarW     = H_PIX / 8;

  typedef enum logic [2:0] {StIdle, StVsync, StVbp, StActive, StVfp} state_e;

  state_e      state_q, state_d;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] l_cnt_q, l_cnt_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] color_q, color_d;
  logic [2:0]  bar_q, bar_d;
  logic [15:0] bar_pix_q, bar_pix_d;

  logic        vsyn_q, vsyn_d;
  logic        href_q, href_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic        line_end, state_last;
  logic [15:0] state_lines;
  logic [15:0] pix, bar_color;

  assign line_end = (h_cnt_q == 16'(LineLen - 1));

  always_comb begin
    state_lines = 16'd1;
    case (state_q)
      StVsync:  state_lines = 16'(VS_LINES);
      StVbp:    state_lines = 16'(VBP_LINES);
      StActive: state_lines = 16'(V_LINES);
      StVfp:    state_lines = 16'(VFP_LINES);
      default:  state_lines = 16'd1;
    endcase
  end

  assign state_last = line_end && (l_cnt_q == state_lines - 16'd1);

  // Next-state: timing counters, frame sequencing and per-frame latching.
  always_comb begin
    state_d = state_q;
    h_cnt_d = line_end ? 16'd0 : h_cnt_q + 16'd1;
    l_cnt_d = l_cnt_q;
    pat_d   = pat_q;
    color_d = color_q;
    if (line_end) begin
      l_cnt_d = state_last ? 16'd0 : l_cnt_q + 16'd1;
    end
    case (state_q)
      StIdle: begin
        h_cnt_d = 16'd0;
        l_cnt_d = 16'd0;
        if (en) begin
          pat_d   = pattern_sel;
          color_d = color_i;
          state_d = StVsync;
        end
      end
      StVsync:  if (state_last) state_d = StVbp;
      StVbp:    if (state_last) state_d = StActive;
      StActive: if (state_last) state_d = StVfp;
      StVfp: begin
        if (state_last) begin
          if (en) begin
            pat_d   = pattern_sel;
            color_d = color_i;
            state_d = StVsync;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bar index tracks x / BarW incrementally; it advances after each completed pixel (odd byte).
  always_comb begin
    bar_d     = bar_q;
    bar_pix_d = bar_pix_q;
    if (state_q == StIdle || line_end) begin
      bar_d     = 3'd0;
      bar_pix_d = 16'd0;
    end else if (h_cnt_q[0] && h_cnt_q < 16'(ActBytes)) begin
      if (bar_pix_q == 16'(BarW - 1)) begin
        bar_pix_d = 16'd0;
        bar_d     = bar_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + 16'd1;
      end
    end
  end

  always_comb begin
    unique case (bar_q)
      3'd0: bar_color = 16'hFFFF;
      3'd1: bar_color = 16'hFFE0;
      3'd2: bar_color = 16'h07FF;
      3'd3: bar_color = 16'h07E0;
      3'd4: bar_color = 16'hF81F;
      3'd5: bar_color = 16'hF800;
      3'd6: bar_color = 16'h001F;
      3'd7: bar_color = 16'h0000;
    endcase
  end

  always_comb begin
    unique case (pat_q)
      2'd0: pix = bar_color;
      2'd1: pix = {1'b0, h_cnt_q[15:1]};
      2'd2: pix = l_cnt_q;
      2'd3: pix = color_q;
    endcase
  end

  // Outputs are a registered image of the current state/counters, so they trail state by a cycle.
  always_comb begin
    busy_d = (state_q != StIdle);
    vsyn_d = (state_q == StVsync);
    href_d = (state_q == StActive) && (h_cnt_q < 16'(ActBytes));
    data_d = 8'd0;
    if (href_d) data_d = h_cnt_q[0] ? pix[7:0] : pix[15:8];
    done_d = (state_q == StVfp) && state_last;
    fcnt_d = fcnt_q + {15'd0, done_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      h_cnt_q   <= 16'd0;
      l_cnt_q   <= 16'd0;
      pat_q     <= 2'd0;
      color_q   <= 16'd0;
      bar_q     <= 3'd0;
      bar_pix_q <= 16'd0;
      vsyn_q    <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= 8'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      fcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      l_cnt_q   <= l_cnt_d;
      pat_q     <= pat_d;
      color_q   <= color_d;
      bar_q     <= bar_d;
      bar_pix_q <= bar_pix_d;
      vsyn_q    <= vsyn_d;
      href_q    <= href_d;
      data_q    <= data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign cmos_vsyn  = vsyn_q;
  assign cmos_href  = href_q;
  assign cmos_data  = data_q;
  assign frame_done = done_q;
  assign busy       = busy_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Self-checking bench for cam_dvp_tx in the small configuration (16 px, 4 blank, 4 lines,
// 1-line porches): 36-cycle lines, 252-cycle frames.
module tb_cam_dvp_tx;

  localparam int LineLen  = 36;
  localparam int FrameLen = 252;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  pattern_sel;
  logic [15:0] color_i;
  logic        cmos_vsyn;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic [15:0] frame_cnt;
  logic        frame_done;
  logic        busy;

  cam_dvp_tx #(
    .H_PIX     (16),
    .H_BLANK   (4),
    .V_LINES   (4),
    .VS_LINES  (1),
    .VBP_LINES (1),
    .VFP_LINES (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pattern_sel (pattern_sel),
    .color_i     (color_i),
    .cmos_vsyn   (cmos_vsyn),
    .cmos_href   (cmos_href),
    .cmos_data   (cmos_data),
    .frame_cnt   (frame_cnt),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef struct {
    logic [1:0]  pat;
    logic [15:0] col;
    int          t;
    logic [7:0]  exp;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  cap [FrameLen];
  logic [15:0] fc_exp;
  int          n_cmp;
  int          n_err;

  // Reference: expected {vsyn, href, data, frame_done, busy} at cycle t after vsyn rises.
  function automatic logic [11:0] model(input logic [1:0] pat, input logic [15:0] col,
                                        input int t);
    int          line = t / LineLen;
    int          h    = t % LineLen;
    int          x    = h / 2;
    int          y    = line - 2;
    logic        hr   = (line >= 2) && (line < 6) && (h < 32);
    logic [15:0] pix;
    logic [7:0]  d;
    case (pat)
      2'd0:    pix = BARS[x / 2];
      2'd1:    pix = 16'(x);
      2'd2:    pix = 16'(y);
      default: pix = col;
    endcase
    d = 8'd0;
    if (hr) d = (h % 2 == 0) ? pix[15:8] : pix[7:0];
    return {line == 0, hr, d, t == FrameLen - 1, 1'b1};
  endfunction

  function automatic logic [27:0] outs();
    return {cmos_vsyn, cmos_href, cmos_data, frame_done, busy, frame_cnt};
  endfunction

  task automatic chk(input string nm, input int t, input logic [27:0] got,
                     input logic [27:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got {vs,hr,data,done,busy,fcnt}=%h required=%h", nm, t, got, exp);
    end
  endtask

  // Checks one frame cycle by cycle; mid-frame the inputs are scrambled, then at chg_t the
  // values for the next frame boundary are applied.
  task automatic run_frame(input logic [1:0] pat, input logic [15:0] col, input logic nen,
                           input logic [1:0] npat, input logic [15:0] ncol,
                           input int chg_t, input int stop_t);
    for (int t = 0; t <= stop_t; t++) begin
      @(negedge clk);
      if (t == FrameLen - 1) fc_exp = fc_exp + 16'd1;
      chk("frame", t, outs(), {model(pat, col, t), fc_exp});
      cap[t] = cmos_data;
      if (t == 0) begin
        pattern_sel = 2'($urandom);
        color_i     = 16'($urandom);
      end
      if (t == chg_t) begin
        en          = nen;
        pattern_sel = npat;
        color_i     = ncol;
      end
    end
  endtask

  task automatic idle_check(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(nm, i, outs(), {12'h000, fc_exp});
    end
  endtask

  // Request a frame from IDLE; outputs must still be idle one cycle after the sampling edge.
  task automatic start(input logic [1:0] pat, input logic [15:0] col);
    en          = 1'b1;
    pattern_sel = pat;
    color_i     = col;
    @(negedge clk);
    chk("start_latency", 0, outs(), {12'h000, fc_exp});
  endtask

  task automatic check_tab(input logic [1:0] pat, input logic [15:0] col);
    foreach (vecs[i]) begin
      if (vecs[i].pat == pat && (pat != 2'd3 || vecs[i].col == col)) begin
        chk("table_byte", vecs[i].t, {20'h0, cap[vecs[i].t]}, {20'h0, vecs[i].exp});
      end
    end
  endtask

  initial begin
    logic [1:0]  p, np;
    logic [15:0] c, nc;
    n_cmp  = 0;
    n_err  = 0;
    fc_exp = 16'd0;

    // Spot bytes; active lines start at t = 72, line y at 72 + 36*y, pixel x at +2x.
    vecs.push_back('{2'd0, 16'h0, 72, 8'hFF});
    vecs.push_back('{2'd0, 16'h0, 73, 8'hFF});
    vecs.push_back('{2'd0, 16'h0, 74, 8'hFF});
    vecs.push_back('{2'd0, 16'h0, 75, 8'hFF});
    vecs.push_back('{2'd0, 16'h0, 76, 8'hFF});
    vecs.push_back('{2'd0, 16'h0, 77, 8'hE0});
    vecs.push_back('{2'd0, 16'h0, 102, 8'h00});
    vecs.push_back('{2'd0, 16'h0, 103, 8'h00});
    vecs.push_back('{2'd0, 16'h0, 116, 8'h07});
    vecs.push_back('{2'd0, 16'h0, 117, 8'hFF});
    vecs.push_back('{2'd0, 16'h0, 107, 8'h00});
    vecs.push_back('{2'd1, 16'h0, 118, 8'h00});
    vecs.push_back('{2'd1, 16'h0, 119, 8'h05});
    vecs.push_back('{2'd1, 16'h0, 210, 8'h00});
    vecs.push_back('{2'd1, 16'h0, 211, 8'h0F});
    for (int y = 0; y < 4; y++) begin
      vecs.push_back('{2'd2, 16'h0, 78 + 36 * y, 8'h00});
      vecs.push_back('{2'd2, 16'h0, 79 + 36 * y, 8'(y)});
    end
    vecs.push_back('{2'd3, 16'h1234, 72, 8'h12});
    vecs.push_back('{2'd3, 16'h1234, 73, 8'h34});
    vecs.push_back('{2'd3, 16'hABCD, 200, 8'hAB});
    vecs.push_back('{2'd3, 16'hABCD, 201, 8'hCD});

    rst_n       = 1'b0;
    en          = 1'b0;
    pattern_sel = 2'd0;
    color_i     = 16'h0;
    #2;
    chk("reset_state", 0, outs(), 28'h0);
    @(negedge clk);
    chk("reset_hold", 0, outs(), 28'h0);
    rst_n = 1'b1;
    idle_check("idle_en_low", 3);

    start(2'd0, 16'h0);
    run_frame(2'd0, 16'h0, 1'b1, 2'd1, 16'h0, 250, FrameLen - 1);
    check_tab(2'd0, 16'h0);
    run_frame(2'd1, 16'h0, 1'b1, 2'd2, 16'h0, 250, FrameLen - 1);
    check_tab(2'd1, 16'h0);
    chk("frame_cnt_two", 0, {12'h0, frame_cnt}, {12'h0, 16'd2});
    run_frame(2'd2, 16'h0, 1'b1, 2'd3, 16'h1234, 250, FrameLen - 1);
    check_tab(2'd2, 16'h0);
    // Colour changes at t=100; only the following frame may pick it up.
    run_frame(2'd3, 16'h1234, 1'b1, 2'd3, 16'hABCD, 100, FrameLen - 1);
    check_tab(2'd3, 16'h1234);
    p = 2'($urandom);
    c = 16'($urandom);
    run_frame(2'd3, 16'hABCD, 1'b1, p, c, 250, FrameLen - 1);
    check_tab(2'd3, 16'hABCD);

    for (int i = 0; i < 5; i++) begin
      np = 2'($urandom);
      nc = 16'($urandom);
      run_frame(p, c, 1'b1, np, nc, int'($urandom_range(1, 250)), FrameLen - 1);
      p = np;
      c = nc;
    end

    // en dropped during active line 2: frame completes, then stays idle.
    run_frame(p, c, 1'b0, p, c, 154, FrameLen - 1);
    idle_check("after_en_drop", 20);

    // Reset in the middle of active line 0.
    start(2'd2, 16'h0);
    run_frame(2'd2, 16'h0, 1'b1, 2'd2, 16'h0, 250, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_active", 0, outs(), 28'h0);
    fc_exp = 16'd0;
    @(negedge clk);
    chk("reset_mid_hold", 0, outs(), 28'h0);
    en          = 1'b1;
    pattern_sel = 2'd1;
    color_i     = 16'h0;
    rst_n       = 1'b1;
    @(negedge clk);
    chk("restart_latency", 0, outs(), {12'h000, fc_exp});
    run_frame(2'd1, 16'h0, 1'b0, 2'd1, 16'h0, 250, FrameLen - 1);
    check_tab(2'd1, 16'h0);
    idle_check("final_idle", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cam_dvp_tx.md
# cam_dvp_tx

- Generates a DVP-style camera byte stream (`cmos_vsyn`, `cmos_href`, `cmos_data`) from internal test patterns.
- Used in place of the OV-series sensor to drive the camera receive path: recv_cam → cam2fifo → SDRAM write.
- This makes frame and line counts deterministic for bring-up and regression.
- Output format matches what the receive path expects:
  - RGB565, two bytes per pixel, high byte first;
  - active-high VSYNC pulse, with the frame starting after its falling edge;
  - HREF high during active bytes.

## Interface
Parameters:
- H_PIX, 800, active pixels per line. Must be a multiple of 8 and ≥ 8.
- H_BLANK, 144, HREF-low clocks per line. Must be ≥ 1.
- V_LINES, 480, active lines per frame. Must be ≥ 1.
- VS_LINES, 3, VSYNC-high duration in line times. Must be ≥ 1.
- VBP_LINES, 17, back-porch line times. Must be ≥ 1.
- VFP_LINES, 10, front-porch line times. Must be ≥ 1.
- Derived: LINE_LEN = 2*H_PIX + H_BLANK; BAR_W = H_PIX/8.

Ports:
- clk  in  1  byte clock; one `cmos_data` byte per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run request; sampled only at frame boundaries.
- pattern_sel  in  2  0 = colour bars, 1 = horizontal ramp, 2 = line index, 3 = solid. Latched at frame start.
- color_i  in  16  solid colour for pattern 3. Latched at frame start.
- cmos_vsyn  out  1  frame sync, active high.
- cmos_href  out  1  line valid.
- cmos_data  out  8  pixel byte.
- frame_cnt  out  16  completed frames; wraps 0xFFFF → 0.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, VSYNC, VBP, ACTIVE, VFP.
- Counters:
  - h_cnt: 0..LINE_LEN-1, wraps;
  - l_cnt: line index within the current state.
- IDLE:
  - all outputs 0 except frame_cnt;
  - if en = 1, latch pattern_sel and color_i, clear h_cnt and l_cnt, go to VSYNC.
- VSYNC:
  - `cmos_vsyn` = 1 for VS_LINES*LINE_LEN cycles;
  - then VBP.
- VBP:
  - vsyn and href both 0 for VBP_LINES*LINE_LEN cycles;
  - then ACTIVE.
- ACTIVE, per line y (0..V_LINES-1):
  - `cmos_href` = 1 for h_cnt 0..2*H_PIX-1, then 0 for H_BLANK cycles;
  - after line V_LINES-1 completes, go to VFP.
- VFP:
  - idle lines for VFP_LINES*LINE_LEN cycles;
  - on the last cycle: frame_cnt += 1 and frame_done pulses;
  - if en = 1: re-latch pattern_sel and color_i, go to VSYNC with no gap;
  - else go to IDLE.
- en deasserted mid-frame: the current frame completes in full; no truncated frames are ever emitted.
- Byte mapping during href:
  - byte index k = h_cnt, pixel x = k >> 1;
  - even k → pix[15:8], odd k → pix[7:0];
  - `cmos_data` = 0 whenever href = 0.
- Patterns:
  - 0 (colour bars): bar = x / BAR_W, computed with a bar counter (no divider). Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1 (ramp): pix = x, zero-extended to 16 bits.
  - 2 (line index): pix = y, zero-extended.
  - 3 (solid): pix = latched color_i.

## Timing
- All outputs are registered.
- Reset, asynchronous, takes effect immediately:
  - state = IDLE;
  - vsyn, href, data, frame_done, busy = 0;
  - frame_cnt = 0.
- Reset asserted mid-frame truncates the frame immediately; the next frame starts from VSYNC.
- Start latency: `en` sampled high in IDLE at edge N → `cmos_vsyn` = 1 and `busy` = 1 after edge N+1.
- Frame length: (VS_LINES + VBP_LINES + V_LINES + VFP_LINES) * LINE_LEN cycles, measured from vsyn rise to the next vsyn rise when en is held high.
- First `cmos_href` rise: (VS_LINES + VBP_LINES) * LINE_LEN cycles after vsyn rise.
- `cmos_data` changes on the same edge as the href transitions; byte k is valid in the same cycle as href with h_cnt = k.
- frame_done is high in the last VFP cycle; frame_cnt updates on the same edge.
- Back-to-back frames: vsyn rises the cycle after frame_done.
- pattern_sel and color_i changes mid-frame have no effect until the next frame boundary.

## Test plan
Small configuration for all scenarios: H_PIX = 16, H_BLANK = 4, V_LINES = 4, VS/VBP/VFP = 1. This gives LINE_LEN = 36 and 252 cycles per frame.
- Reset, then en = 1 for 2 frames:
  - vsyn high exactly 36 cycles;
  - first href rise 72 cycles after vsyn rise;
  - 4 href pulses of 32 cycles each, separated by 4 low cycles;
  - vsyn period 252;
  - frame_cnt = 2.
- pattern 0:
  - line 0 bytes: FF FF FF FF (pixels 0–1), then FF E0 for pixels 2–3;
  - last pixel (x = 15) bytes: 00 00.
- pattern 2: every byte pair on line y equals 00,y for y = 0..3. pattern 1: pixel x bytes = 00,x.
- Drop en during line 2:
  - frame completes all 4 lines, frame_done pulses once;
  - busy falls 1 cycle later;
  - vsyn stays 0 thereafter.
- Change color_i from 1234 to ABCD mid-frame with pattern 3:
  - current frame emits 12 34;
  - next frame emits AB CD.
- Assert rst_n = 0 mid-ACTIVE:
  - all outputs 0 immediately, frame_cnt = 0;
  - after release with en = 1, vsyn rises 1 cycle after the first sampling edge.
